// File: rtl/demapper_if.sv
// Byte-stream payload channel from the demapper toward the UART TX FIFO.
interface demapper_if;
  logic [7:0] o_pyld_data;
  logic       o_pyld_data_valid;
  logic       i_pyld_data_ready;

  modport master (
    output o_pyld_data,
    output o_pyld_data_valid,
    input  i_pyld_data_ready
  );

  modport slave (
    input  o_pyld_data,
    input  o_pyld_data_valid,
    output i_pyld_data_ready
  );
endinterface

// File: rtl/demapper.sv
// OTN receive demapper: FAS hunt on the serial line, one-frame payload buffer,
// CRC-8 check, byte-stream release and serial ARQ acknowledge.
module demapper #(
  parameter int unsigned PYLD_BYTES   = 16,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned ACK_LEN      = 8,
  parameter logic [15:0] FAS          = 16'hF628
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
  output logic       o_otn_tx_ack,
  output logic       o_frame_ok,
  output logic       o_crc_err,
  output logic       o_frame_drop,
  demapper_if.master pyld
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
  localparam int unsigned BW = $clog2(PYLD_BYTES + 1);
  localparam int unsigned AW = $clog2(ACK_LEN + 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_PYLD,
    S_CHK,
    S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [14:0]     hunt_q, hunt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [6:0]      byte_sr_q, byte_sr_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      crc_rx_q, crc_rx_d;
  logic            cmp_pend_q, cmp_pend_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            drop_q, drop_d;
  logic [7:0]      buf_q [PYLD_BYTES];

  logic            strobe;
  logic [15:0]     hunt_shift;
  logic [7:0]      new_byte;
  logic [7:0]      crc_bit;
  logic            xfer;
  logic            drain_last;
  logic            buf_free;
  logic            buf_we;
  logic [IW-1:0]   wr_idx;
  logic            crc_match;
  logic            drain_start;
  logic            ack_req;

  assign strobe      = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign clk_cnt_d   = strobe ? '0 : clk_cnt_q + CW'(1);
  assign hunt_shift  = {hunt_q, i_otn_rx_data};
  assign new_byte    = {byte_sr_q, i_otn_rx_data};
  assign crc_bit     = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ i_otn_rx_data) ? 8'h07 : 8'h00);
  assign wr_idx      = byte_idx_q[IW-1:0];

  // A drain finishing on this very cycle frees the buffer for a frame whose FAS lands now.
  assign xfer        = valid_q & pyld.i_pyld_data_ready;
  assign drain_last  = xfer && (rd_idx_q == IW'(PYLD_BYTES - 1));
  assign buf_free    = !valid_q || drain_last;

  assign crc_match   = (crc_rx_q == crc_q);
  assign drain_start = cmp_pend_q && (crc_match || !i_arq_en);
  assign ack_req     = cmp_pend_q && crc_match && i_arq_en;

  always_comb begin
    state_d    = state_q;
    hunt_d     = hunt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    byte_sr_d  = byte_sr_q;
    crc_d      = crc_q;
    crc_rx_d   = crc_rx_q;
    cmp_pend_d = 1'b0;
    drop_d     = 1'b0;
    buf_we     = 1'b0;
    if (strobe) begin
      case (state_q)
        S_HUNT: begin
          hunt_d = hunt_shift[14:0];
          if (hunt_shift == FAS) begin
            hunt_d     = '0;
            bit_idx_d  = '0;
            byte_idx_d = '0;
            byte_sr_d  = '0;
            crc_d      = '0;
            state_d    = buf_free ? S_PYLD : S_SKIP;
          end
        end
        S_PYLD: begin
          crc_d     = crc_bit;
          byte_sr_d = new_byte[6:0];
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            buf_we     = 1'b1;
            byte_idx_d = byte_idx_q + BW'(1);
            if (byte_idx_q == BW'(PYLD_BYTES - 1)) begin
              byte_idx_d = '0;
              state_d    = S_CHK;
            end
          end
        end
        S_CHK: begin
          crc_rx_d  = {crc_rx_q[6:0], i_otn_rx_data};
          bit_idx_d = bit_idx_q + 3'd1;
          // Compare happens next cycle while already hunting, so no line bit is lost.
          if (bit_idx_q == 3'd7) begin
            cmp_pend_d = 1'b1;
            state_d    = S_HUNT;
          end
        end
        S_SKIP: begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            byte_idx_d = byte_idx_q + BW'(1);
            if (byte_idx_q == BW'(PYLD_BYTES)) begin
              byte_idx_d = '0;
              drop_d     = 1'b1;
              state_d    = S_HUNT;
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_comb begin
    valid_d  = valid_q;
    rd_idx_d = rd_idx_q;
    if (xfer) begin
      if (drain_last) begin
        valid_d  = 1'b0;
        rd_idx_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + IW'(1);
      end
    end
    if (drain_start) begin
      valid_d  = 1'b1;
      rd_idx_d = '0;
    end
  end

  always_comb begin
    ok_d      = drain_start;
    err_d     = cmp_pend_q && !crc_match;
    ack_cnt_d = ack_cnt_q;
    if (ack_req) begin
      ack_cnt_d = AW'(ACK_LEN);
    end else if (ack_cnt_q != '0) begin
      ack_cnt_d = ack_cnt_q - AW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_HUNT;
      clk_cnt_q  <= '0;
      hunt_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      byte_sr_q  <= '0;
      crc_q      <= '0;
      crc_rx_q   <= '0;
      cmp_pend_q <= 1'b0;
      rd_idx_q   <= '0;
      valid_q    <= 1'b0;
      ack_cnt_q  <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      hunt_q     <= hunt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      byte_sr_q  <= byte_sr_d;
      crc_q      <= crc_d;
      crc_rx_q   <= crc_rx_d;
      cmp_pend_q <= cmp_pend_d;
      rd_idx_q   <= rd_idx_d;
      valid_q    <= valid_d;
      ack_cnt_q  <= ack_cnt_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < PYLD_BYTES; i++) begin
        buf_q[i] <= '0;
      end
    end else if (buf_we) begin
      buf_q[wr_idx] <= new_byte;
    end
  end

  assign pyld.o_pyld_data       = valid_q ? buf_q[rd_idx_q] : '0;
  assign pyld.o_pyld_data_valid = valid_q;
  assign o_otn_tx_ack           = (ack_cnt_q != '0);
  assign o_frame_ok             = ok_q;
  assign o_crc_err              = err_q;
  assign o_frame_drop           = drop_q;

endmodule

// File: tb/tb_demapper.sv
// Directed + randomized bench for demapper: two instances (1 and 4 clocks per bit)
// checked against a frame-level reference model.
module tb_demapper;
  localparam int unsigned NB = 4;
  localparam logic [15:0] FAS = 16'hF628;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line1 = 1'b0;
  logic line4 = 1'b0;
  logic arq = 1'b1;
  logic ack1, ok1, err1, drop1;
  logic ack4, ok4, err4, drop4;

  demapper_if if1 ();
  demapper_if if4 ();

  always #5 clk = ~clk;

  demapper #(.PYLD_BYTES(NB), .CLKS_PER_BIT(1), .ACK_LEN(8), .FAS(FAS)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_otn_rx_data(line1), .i_arq_en(arq),
    .o_otn_tx_ack(ack1), .o_frame_ok(ok1), .o_crc_err(err1), .o_frame_drop(drop1),
    .pyld(if1.master)
  );

  demapper #(.PYLD_BYTES(NB), .CLKS_PER_BIT(4), .ACK_LEN(8), .FAS(FAS)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_otn_rx_data(line4), .i_arq_en(arq),
    .o_otn_tx_ack(ack4), .o_frame_ok(ok4), .o_crc_err(err4), .o_frame_drop(drop4),
    .pyld(if4.master)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Observed activity, collected on the falling edge.
  logic [7:0]  got1[$], got4[$];
  int unsigned gcyc1[$], gcyc4[$], runs1[$], runs4[$];
  int unsigned ok_n1 = 0, err_n1 = 0, drop_n1 = 0, ok_n4 = 0, err_n4 = 0;
  int unsigned okcyc1 = 0, ackst1 = 0, run1 = 0, run4 = 0, viol1 = 0;
  logic        pv1 = 1'b0, pr1 = 1'b0;
  logic [7:0]  pd1 = '0;

  always @(negedge clk) begin
    if (rst) begin
      pv1 = 1'b0; run1 = 0; run4 = 0;
    end else begin
      if (pv1 && !pr1 && (!if1.o_pyld_data_valid || if1.o_pyld_data !== pd1)) viol1++;
      if (if1.o_pyld_data_valid && if1.i_pyld_data_ready) begin
        got1.push_back(if1.o_pyld_data); gcyc1.push_back(cyc);
      end
      if (ok1) begin ok_n1++; okcyc1 = cyc; end
      if (err1) err_n1++;
      if (drop1) drop_n1++;
      if (ack1) begin
        if (run1 == 0) ackst1 = cyc;
        run1++;
      end else if (run1 != 0) begin
        runs1.push_back(run1); run1 = 0;
      end
      pv1 = if1.o_pyld_data_valid; pr1 = if1.i_pyld_data_ready; pd1 = if1.o_pyld_data;
      if (if4.o_pyld_data_valid && if4.i_pyld_data_ready) begin
        got4.push_back(if4.o_pyld_data); gcyc4.push_back(cyc);
      end
      if (ok4) ok_n4++;
      if (err4) err_n4++;
      if (ack4) run4++;
      else if (run4 != 0) begin runs4.push_back(run4); run4 = 0; end
    end
  end

  // Reference model state for dut1.
  logic [7:0]  pl [NB];
  logic [7:0]  exp1[$];
  int unsigned expr1[$];
  int unsigned ok_e1 = 0, err_e1 = 0, drop_e1 = 0;
  int          dptr1 = 0, rptr1 = 0;
  logic [15:0] hist1 = '0;
  int unsigned lastc, base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8();
    logic [7:0] c = 8'h00;
    for (int k = 0; k < int'(NB); k++) begin
      c = c ^ pl[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic model1(input logic [7:0] c, input logic busy);
    logic good;
    good = (c == crc8());
    if (busy) drop_e1++;
    else begin
      if (good || !arq) begin
        ok_e1++;
        for (int k = 0; k < int'(NB); k++) exp1.push_back(pl[k]);
      end
      if (!good) err_e1++;
      if (good && arq) expr1.push_back(8);
    end
  endtask

  task automatic bit1(input logic b);
    line1 = b; hist1 = {hist1[14:0], b};
    @(posedge clk); #1;
  endtask

  task automatic byte1(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit1(v[i]);
  endtask

  task automatic idle1(input int unsigned n);
    logic b;
    for (int unsigned i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      if ({hist1[14:0], b} == FAS) b = ~b;
      bit1(b);
    end
  endtask

  task automatic frame1(input logic [7:0] c);
    byte1(FAS[15:8]); byte1(FAS[7:0]);
    for (int k = 0; k < int'(NB); k++) byte1(pl[k]);
    byte1(c);
    hist1 = '0;
    lastc = cyc;
  endtask

  task automatic bit4(input logic b);
    line4 = b;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic frame4(input logic [7:0] c);
    logic [7:0] v;
    for (int n = 0; n < int'(NB) + 3; n++) begin
      v = (n == 0) ? FAS[15:8] : (n == 1) ? FAS[7:0] : (n == int'(NB) + 2) ? c : pl[n-2];
      for (int i = 7; i >= 0; i--) bit4(v[i]);
    end
  endtask

  task automatic check_cnt1();
    chk("ok_count", ok_n1, ok_e1);
    chk("crc_err_count", err_n1, err_e1);
    chk("drop_count", drop_n1, drop_e1);
  endtask

  task automatic check_data1();
    chk("byte_count", got1.size(), exp1.size());
    for (int k = dptr1; k < got1.size() && k < exp1.size(); k++) chk("byte", got1[k], exp1[k]);
    dptr1 = exp1.size();
    chk("ack_count", runs1.size(), expr1.size());
    for (int k = rptr1; k < runs1.size() && k < expr1.size(); k++) chk("ack_len", runs1[k], expr1[k]);
    rptr1 = expr1.size();
    chk("stall_stable", viol1, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ack"}, ack1, 1'b0);
    chk({tag, "_valid"}, if1.o_pyld_data_valid, 1'b0);
    chk({tag, "_data"}, if1.o_pyld_data, 8'h00);
    chk({tag, "_ok"}, ok1, 1'b0);
    chk({tag, "_err"}, err1, 1'b0);
    chk({tag, "_drop"}, drop1, 1'b0);
  endtask

  initial begin
    logic [7:0] c;
    logic [7:0] pp;
    logic [7:0] first;
    if1.i_pyld_data_ready = 1'b1;
    if4.i_pyld_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_ack4", ack4, 1'b0);
    chk("reset_valid4", if4.o_pyld_data_valid, 1'b0);
    rst = 1'b0;

    // Known-good frame with exact timing.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    idle1(5);
    base = got1.size();
    model1(8'hE3, 1'b0);
    frame1(8'hE3);
    idle1(14);
    check_cnt1();
    chk("ok_time", okcyc1, lastc + 1);
    chk("ack_start", ackst1, lastc + 1);
    for (int k = 0; k < int'(NB); k++) chk("byte_time", gcyc1[base + k], lastc + 1 + k);
    check_data1();

    // Bad CRC with and without ARQ.
    model1(8'hE2, 1'b0);
    frame1(8'hE2);
    idle1(14);
    check_cnt1();
    check_data1();
    arq = 1'b0;
    model1(8'hE2, 1'b0);
    frame1(8'hE2);
    idle1(14);
    check_cnt1();
    check_data1();

    // Partial FAS prefix (F6 29) then random frames with random idle gaps.
    byte1(8'hF6);
    pp = 8'h29;
    for (int i = 7; i >= 0; i--) bit1(pp[i]);
    idle1($urandom_range(0, 12));
    for (int f = 0; f < 12; f++) begin
      arq = 1'($urandom_range(0, 1));
      for (int k = 0; k < int'(NB); k++) pl[k] = 8'($urandom);
      c = crc8();
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      model1(c, 1'b0);
      frame1(c);
      idle1($urandom_range(2, 20));
      check_cnt1();
    end
    idle1(16);
    check_data1();

    // Stalled drain: second back-to-back frame is dropped, first stays intact.
    arq = 1'b1;
    if1.i_pyld_data_ready = 1'b0;
    for (int k = 0; k < int'(NB); k++) pl[k] = 8'($urandom);
    first = pl[0];
    model1(crc8(), 1'b0);
    frame1(crc8());
    for (int k = 0; k < int'(NB); k++) pl[k] = 8'($urandom);
    model1(crc8(), 1'b1);
    frame1(crc8());
    idle1(3);
    check_cnt1();
    chk("stall_valid", if1.o_pyld_data_valid, 1'b1);
    chk("stall_data", if1.o_pyld_data, first);
    if1.i_pyld_data_ready = 1'b1;
    idle1(12);
    check_data1();

    // Reset during a held drain with ACK active.
    if1.i_pyld_data_ready = 1'b0;
    for (int k = 0; k < int'(NB); k++) pl[k] = 8'($urandom);
    ok_e1++;
    frame1(crc8());
    idle1(2);
    chk("pre_reset_ack", ack1, 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_drain");
    @(posedge clk); #1;
    rst = 1'b0; hist1 = '0;
    if1.i_pyld_data_ready = 1'b1;

    // Reset at payload byte 2, then a normal frame.
    idle1(4);
    byte1(FAS[15:8]); byte1(FAS[7:0]); byte1(8'h55); byte1(8'hAA);
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_pyld");
    @(posedge clk); #1;
    rst = 1'b0; hist1 = '0;
    idle1(6);
    for (int k = 0; k < int'(NB); k++) pl[k] = 8'($urandom);
    model1(crc8(), 1'b0);
    frame1(crc8());
    idle1(14);
    check_cnt1();
    check_data1();

    // Four clocks per bit.
    line1 = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    repeat (8) bit4(1'b0);
    frame4(8'hE3);
    repeat (8) bit4(1'b0);
    chk("cpb4_ok", ok_n4, 1);
    chk("cpb4_err", err_n4, 0);
    chk("cpb4_bytes", got4.size(), NB);
    for (int k = 0; k < int'(NB); k++) chk("cpb4_byte", got4[k], pl[k]);
    for (int k = 1; k < int'(NB); k++) chk("cpb4_byte_time", gcyc4[k], gcyc4[k-1] + 1);
    chk("cpb4_acks", runs4.size(), 1);
    chk("cpb4_ack_len", runs4[0], 8);
    frame4(8'hE2);
    repeat (8) bit4(1'b0);
    chk("cpb4_err2", err_n4, 1);
    chk("cpb4_ok2", ok_n4, 1);
    chk("cpb4_bytes2", got4.size(), NB);
    chk("cpb4_acks2", runs4.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
